spi_master_reg: RTL

- SPI master register-access initiator: the host-side counterpart of the CPLD's SPI slave register file.
- Turns a single register read/write request into the two-frame SPI transaction: an address frame, then a data frame.
- Link format: mode 0, 16-bit frames, MSB first.
- Used on bench and companion boards to drive the CPLD register map (PWM, RC, sonar, version, status).

---
 rtl/spi_master_reg_if.sv | 46 ++++
 rtl/spi_master_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_reg_if.sv
// ---------------------------------------------------------------------------
// spi_master_reg_if
// Host-side request/response bus of the SPI register-access master.
//
// Signals:
//   req        host -> master  transaction request (sampled only while idle)
//   req_rd     host -> master  1 = register read, 0 = register write
//   req_addr   host -> master  14-bit register address
//   req_wdata  host -> master  16-bit write data (ignored for reads)
//   busy       master -> host  transaction in progress
//   done       master -> host  one-cycle completion pulse
//   rdata      master -> host  read data, valid from done onward
//
// Modports:
//   master  the host that issues requests
//   slave   the spi_master_reg block that serves them
// ---------------------------------------------------------------------------
interface spi_master_reg_if;
  logic        req;
  logic        req_rd;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;

  modport master (
    output req,
    output req_rd,
    output req_addr,
    output req_wdata,
    input  busy,
    input  done,
    input  rdata
  );

  modport slave (
    input  req,
    input  req_rd,
    input  req_addr,
    input  req_wdata,
    output busy,
    output done,
    output rdata
  );
endinterface

// File: rtl/spi_master_reg.sv
// ---------------------------------------------------------------------------
// spi_master_reg
// SPI master that turns one register read/write request into the two-frame
// transaction understood by the CPLD's SPI slave register file: an address
// frame {op, addr} followed by a data frame. SPI mode 0, 16-bit frames,
// MSB first. op = 2'b11 for reads, 2'b00 for writes.
//
// Parameters:
//   CLK_DIV    SPI half-period in clk cycles (legal 2..255)
//   FRAME_GAP  clk cycles chip select stays high between frames (1..2399)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   host       request/response bus (spi_master_reg_if.slave)
//   spi_sclk   SPI clock, idles low
//   spi_cs_n   chip select, active low
//   spi_mosi   master out, slave in
//   spi_miso   master in, slave out
//
// Every SPI pin and host output is a flop, so the pins are glitch-free and
// an asynchronous reset forces them to their idle levels without a clock.
// ---------------------------------------------------------------------------
module spi_master_reg #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned FRAME_GAP = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_master_reg_if.slave host,
  output logic            spi_sclk,
  output logic            spi_cs_n,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    FRAME1,
    GAP,
    FRAME2,
    DONE
  } state_t;

  localparam logic [7:0]  HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [11:0] GAP_LAST  = 12'(FRAME_GAP - 1);
  localparam logic [4:0]  LAST_BIT  = 5'd16;

  state_t      state,     state_nxt;
  logic [7:0]  half_cnt,  half_cnt_nxt;
  logic [4:0]  bit_cnt,   bit_cnt_nxt;
  logic [11:0] gap_cnt,   gap_cnt_nxt;
  logic [15:0] tx_sr,     tx_sr_nxt;
  logic [15:0] rx_sr,     rx_sr_nxt;
  logic [15:0] data_word, data_word_nxt;
  logic [15:0] rdata_q,   rdata_nxt;
  logic        is_rd,     is_rd_nxt;
  logic        busy_q,    busy_nxt;
  logic        done_q,    done_nxt;
  logic        sclk_q,    sclk_nxt;
  logic        cs_n_q,    cs_n_nxt;
  logic        mosi_q,    mosi_nxt;

  logic        start_frame;
  logic [15:0] start_word;
  logic        end_of_frame;

  // Next-state and next-output logic. Both frames share one sequencer:
  // a low half of CLK_DIV cycles, then 16 high/low pairs, the last low
  // half doubling as the hold time before chip select rises (33 halves).
  always_comb begin
    state_nxt     = state;
    half_cnt_nxt  = half_cnt;
    bit_cnt_nxt   = bit_cnt;
    gap_cnt_nxt   = gap_cnt;
    tx_sr_nxt     = tx_sr;
    rx_sr_nxt     = rx_sr;
    data_word_nxt = data_word;
    rdata_nxt     = rdata_q;
    is_rd_nxt     = is_rd;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    sclk_nxt      = sclk_q;
    cs_n_nxt      = cs_n_q;
    mosi_nxt      = mosi_q;
    start_frame   = 1'b0;
    start_word    = 16'h0000;
    end_of_frame  = 1'b0;

    case (state)
      IDLE: begin
        if (host.req) begin
          is_rd_nxt     = host.req_rd;
          data_word_nxt = host.req_rd ? 16'h0000 : host.req_wdata;
          busy_nxt      = 1'b1;
          state_nxt     = FRAME1;
          start_frame   = 1'b1;
          start_word    = {(host.req_rd ? 2'b11 : 2'b00), host.req_addr};
        end
      end

      FRAME1, FRAME2: begin
        if (half_cnt != HALF_LAST) begin
          half_cnt_nxt = half_cnt + 8'd1;
        end else begin
          half_cnt_nxt = 8'd0;
          if (sclk_q) begin
            // Falling edge: miso is captured at the end of the high half.
            // mosi moves on except after the 16th bit, so the last bit
            // stays on the wire through the final low half.
            sclk_nxt  = 1'b0;
            rx_sr_nxt = {rx_sr[14:0], spi_miso};
            if (bit_cnt != LAST_BIT) begin
              tx_sr_nxt = {tx_sr[14:0], 1'b0};
              mosi_nxt  = tx_sr[14];
            end
          end else if (bit_cnt != LAST_BIT) begin
            sclk_nxt    = 1'b1;
            bit_cnt_nxt = bit_cnt + 5'd1;
          end else begin
            end_of_frame = 1'b1;
          end
        end

        if (end_of_frame) begin
          cs_n_nxt = 1'b1;
          mosi_nxt = 1'b0;
          if (state == FRAME1) begin
            state_nxt   = GAP;
            gap_cnt_nxt = 12'd0;
          end else begin
            // The address-frame capture was overwritten when FRAME2 started,
            // so rx_sr holds only the data frame here.
            state_nxt = DONE;
            done_nxt  = 1'b1;
            if (is_rd) begin
              rdata_nxt = rx_sr;
            end
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = FRAME2;
          start_frame = 1'b1;
          start_word  = data_word;
        end else begin
          gap_cnt_nxt = gap_cnt + 12'd1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b0;
        mosi_nxt  = 1'b0;
      end
    endcase

    // Frame launch: chip select falls with the MSB already on mosi.
    if (start_frame) begin
      cs_n_nxt     = 1'b0;
      sclk_nxt     = 1'b0;
      mosi_nxt     = start_word[15];
      tx_sr_nxt    = start_word;
      rx_sr_nxt    = 16'h0000;
      half_cnt_nxt = 8'd0;
      bit_cnt_nxt  = 5'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      half_cnt  <= 8'd0;
      bit_cnt   <= 5'd0;
      gap_cnt   <= 12'd0;
      tx_sr     <= 16'h0000;
      rx_sr     <= 16'h0000;
      data_word <= 16'h0000;
      rdata_q   <= 16'h0000;
      is_rd     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      half_cnt  <= half_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      tx_sr     <= tx_sr_nxt;
      rx_sr     <= rx_sr_nxt;
      data_word <= data_word_nxt;
      rdata_q   <= rdata_nxt;
      is_rd     <= is_rd_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      sclk_q    <= sclk_nxt;
      cs_n_q    <= cs_n_nxt;
      mosi_q    <= mosi_nxt;
    end
  end

  assign host.busy  = busy_q;
  assign host.done  = done_q;
  assign host.rdata = rdata_q;
  assign spi_sclk   = sclk_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_mosi   = mosi_q;

endmodule
